// File: rtl/tick_sched_pkg.sv
// tick_sched_pkg -- shared definitions for the tick scheduler.
//   state_t    : scheduler FSM states (IDLE, RUN, HALT)
//   DIV_MIN    : smallest divide ratio accepted; smaller requests are raised to it
//   DIV_RESET  : divide ratio held after reset
//   clamp_div  : applies the DIV_MIN floor to a requested ratio
package tick_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int unsigned DIV_MIN   = 2;
  localparam int unsigned DIV_RESET = 3;

  function automatic int unsigned clamp_div(input int unsigned d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/tick_rr_arbiter.sv
// tick_rr_arbiter -- picks one requester per tick.
// Build option TICK_SCHED_RR_EN:
//   defined   : round-robin; the search starts just after the last granted
//               index, and the pointer moves only when a grant is issued.
//   undefined : fixed priority, lowest index wins, no state.
// Ports:
//   clk, reset : clock / async active-high reset (round-robin build only)
//   req        : per-requester request levels
//   advance    : high in a tick cycle; grant is zero otherwise
//   grant      : one-hot-or-zero grant
module tick_rr_arbiter #(
  parameter int unsigned NREQ = 3
) (
`ifdef TICK_SCHED_RR_EN
  input  logic            clk,
  input  logic            reset,
`endif
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);

`ifdef TICK_SCHED_RR_EN
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] last;
  logic [PW-1:0] gidx;
  logic          found;
  int unsigned   idx;

  // Walk offsets 1..NREQ from the last grant; the inner constant-index loop
  // keeps every req/grant select at a fixed bit position.
  always_comb begin
    grant = '0;
    gidx  = last;
    found = 1'b0;
    idx   = 0;
    if (advance) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        idx = (32'(last) + 32'd1 + i) % NREQ;
        for (int unsigned j = 0; j < NREQ; j++) begin
          if (!found && (j == idx) && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            gidx     = PW'(j);
          end
        end
      end
    end
  end

  // Reset value makes req[0] the first index searched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= PW'(NREQ - 1);
    end else if (found) begin
      last <= gidx;
    end
  end
`else
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    if (advance) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req[i]) begin
          found    = 1'b1;
          grant[i] = 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler -- divides clk by a programmable ratio N and hands each
// resulting tick to one of NREQ requesters.
// Build option TICK_SCHED_RR_EN selects round-robin arbitration; otherwise
// fixed priority (lowest index) is used.
// Ports:
//   clk, reset : clock / async active-high reset
//   cfg_valid  : load request for the divide ratio (honoured only in IDLE)
//   cfg_div    : requested ratio N (values below 2 run with period 2)
//   cfg_ready  : high in IDLE, when a load is accepted
//   start      : begin ticking (IDLE only, ignored if stop is also high)
//   stop       : finish the current period, then return to IDLE
//   req        : per-requester request levels
//   grant      : one-hot-or-zero grant, non-zero only in tick cycles
//   tick       : one-cycle pulse every N cycles while running
//   busy       : high whenever not IDLE
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DIVW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_valid,
  input  logic [DIVW-1:0] cfg_div,
  output logic            cfg_ready,
  input  logic            start,
  input  logic            stop,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            tick,
  output logic            busy
);

  state_t          state;
  logic [DIVW-1:0] count;
  logic [DIVW-1:0] div_reg;

  // Outputs decode registered state only; req reaches grant through the
  // arbiter, gated by tick.
  assign busy      = (state != IDLE);
  assign cfg_ready = (state == IDLE);
  assign tick      = busy && (count == (div_reg - DIVW'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      div_reg <= DIVW'(DIV_RESET);
    end else begin
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            div_reg <= DIVW'(clamp_div(32'(cfg_div)));
          end
          if (start && !stop) begin
            state <= RUN;
            count <= '0;
          end
        end
        RUN: begin
          count <= tick ? '0 : count + DIVW'(1);
          if (stop) begin
            state <= tick ? IDLE : HALT;
          end
        end
        HALT: begin
          count <= tick ? '0 : count + DIVW'(1);
          if (tick) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  tick_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
`ifdef TICK_SCHED_RR_EN
    .clk     (clk),
    .reset   (reset),
`endif
    .req     (req),
    .advance (tick),
    .grant   (grant)
  );

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler -- directed checks of tick_scheduler (NREQ=3, DIVW=4).
// Cycle k is the k-th clock cycle after the edge that accepts start.
// Expected grants follow TICK_SCHED_RR_EN in the same way the RTL build does.
module tb_tick_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid;
  logic [3:0] cfg_div;
  logic       cfg_ready;
  logic       start;
  logic       stop;
  logic [2:0] req;
  logic [2:0] grant;
  logic       tick;
  logic       busy;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tick_scheduler #(
    .NREQ (3),
    .DIVW (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .start     (start),
    .stop      (stop),
    .req       (req),
    .grant     (grant),
    .tick      (tick),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cfg_valid = 1'b0; cfg_div = '0; start = 1'b0; stop = 1'b0; req = '0;
    step(); step();
    tests++;
    if ({tick, grant, busy, cfg_ready} !== {1'b0, 3'b000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_hold tick/grant/busy/rdy got %b%b%b%b exp 0 000 0 1", tick, grant, busy, cfg_ready);
    end
    reset = 1'b0;
    step();
    tests++;
    if ({tick, grant, busy, cfg_ready} !== {1'b0, 3'b000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_after tick/grant/busy/rdy got %b%b%b%b exp 0 000 0 1", tick, grant, busy, cfg_ready);
    end
  endtask

  // Default ratio 3: ticks at 3,6,9; stop in cycle 9 ends the run.
  task automatic test_default_period();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      stop = (k == 9);
      tests++;
      if (tick !== (k % 3 == 0)) begin
        errors++;
        $display("FAIL default_tick cycle %0d got %b exp %b", k, tick, (k % 3 == 0));
      end
      tests++;
      if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
        errors++;
        $display("FAIL default_busy cycle %0d busy %b rdy %b exp 1 0", k, busy, cfg_ready);
      end
      step();
    end
    stop = 1'b0;
    tests++;
    if (busy !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL default_end busy %b tick %b exp 0 0", busy, tick);
    end
  endtask

  task automatic test_cfg_load();
    // cfg_div=5 loaded together with start; a cfg in RUN must be ignored.
    cfg_valid = 1'b1; cfg_div = 4'd5; start = 1'b1;
    tests++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_ready_idle got %b exp 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0; start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      cfg_valid = (k == 2);
      cfg_div   = (k == 2) ? 4'd7 : 4'd0;
      stop      = (k == 10);
      if (k == 2) begin
        tests++;
        if (cfg_ready !== 1'b0) begin
          errors++;
          $display("FAIL cfg_ready_run got %b exp 0", cfg_ready);
        end
      end
      tests++;
      if (tick !== (k % 5 == 0)) begin
        errors++;
        $display("FAIL cfg5_tick cycle %0d got %b exp %b", k, tick, (k % 5 == 0));
      end
      step();
    end
    cfg_valid = 1'b0; stop = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL cfg5_end busy got %b exp 0", busy);
    end

    // cfg_div=0 loaded alone in IDLE, run started later: period 2.
    cfg_valid = 1'b1; cfg_div = 4'd0;
    step();
    cfg_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      stop = (k == 4);
      tests++;
      if (tick !== (k % 2 == 0)) begin
        errors++;
        $display("FAIL cfg0_tick cycle %0d got %b exp %b", k, tick, (k % 2 == 0));
      end
      step();
    end
    stop = 1'b0;

    // cfg_div=1 with start: period 2, stop on the first tick.
    cfg_valid = 1'b1; cfg_div = 4'd1; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0; cfg_div = 4'd0;
    for (int k = 1; k <= 3; k++) begin
      stop = (k == 2);
      tests++;
      if (tick !== (k == 2) || busy !== (k <= 2)) begin
        errors++;
        $display("FAIL cfg1 cycle %0d tick %b busy %b exp %b %b", k, tick, busy, (k == 2), (k <= 2));
      end
      step();
    end
    stop = 1'b0;
  endtask

  task automatic test_stop_halt();
    // N=4, stop in cycle 6 -> HALT, final tick 8, IDLE in 9; start in HALT ignored.
    cfg_valid = 1'b1; cfg_div = 4'd4; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      stop  = (k == 6);
      start = (k == 7);
      tests++;
      if (tick !== (k == 4 || k == 8) || busy !== (k <= 8)) begin
        errors++;
        $display("FAIL halt cycle %0d tick %b busy %b exp %b %b", k, tick, busy, (k == 4 || k == 8), (k <= 8));
      end
      step();
    end
    stop = 1'b0; start = 1'b0;

    // stop coinciding with the tick in cycle 4 -> IDLE in cycle 5.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      stop = (k == 4);
      tests++;
      if (tick !== (k == 4) || busy !== (k <= 4)) begin
        errors++;
        $display("FAIL stop_on_tick cycle %0d tick %b busy %b exp %b %b", k, tick, busy, (k == 4), (k <= 4));
      end
      step();
    end
    stop = 1'b0;
  endtask

  task automatic test_start_stop_both();
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    step(); step(); step(); step();
    tests++;
    if (busy !== 1'b0 || tick !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_both busy %b tick %b exp 0 0", busy, tick);
    end
  endtask

  task automatic test_arbitration();
    logic [2:0] exp_g;
    logic [2:0] rr_seq [4];
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    reset = 1'b1;
    step();
    reset = 1'b0;
    cfg_valid = 1'b1; cfg_div = 4'd2; start = 1'b1; req = 3'b111;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      stop = (k == 8);
`ifdef TICK_SCHED_RR_EN
      exp_g = (k % 2 == 0) ? rr_seq[k / 2 - 1] : 3'b000;
`else
      exp_g = (k % 2 == 0) ? 3'b001 : 3'b000;
`endif
      tests++;
      if (grant !== exp_g || tick !== (k % 2 == 0)) begin
        errors++;
        $display("FAIL arb cycle %0d grant %b tick %b exp %b %b", k, grant, tick, exp_g, (k % 2 == 0));
      end
      step();
    end
    stop = 1'b0; req = '0;
  endtask

  task automatic test_req_zero();
    logic [2:0] req_seq [4];
    logic [2:0] exp_seq [4];
    logic [2:0] exp_g;
    req_seq = '{3'b111, 3'b000, 3'b111, 3'b101};
`ifdef TICK_SCHED_RR_EN
    exp_seq = '{3'b001, 3'b000, 3'b010, 3'b100};
`else
    exp_seq = '{3'b001, 3'b000, 3'b001, 3'b001};
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    cfg_valid = 1'b1; cfg_div = 4'd2; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      stop  = (k == 8);
      req   = (k % 2 == 0) ? req_seq[k / 2 - 1] : 3'b111;
      exp_g = (k % 2 == 0) ? exp_seq[k / 2 - 1] : 3'b000;
      #1;
      tests++;
      if (grant !== exp_g || tick !== (k % 2 == 0)) begin
        errors++;
        $display("FAIL req_zero cycle %0d grant %b tick %b exp %b %b", k, grant, tick, exp_g, (k % 2 == 0));
      end
      step();
    end
    stop = 1'b0; req = '0;
  endtask

  task automatic test_reset_mid_run();
    // Load 5, start, reset in cycle 2: aborts at once and restores ratio 3.
    cfg_valid = 1'b1; cfg_div = 4'd5; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    step();
    reset = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || tick !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async busy %b tick %b rdy %b exp 0 0 1", busy, tick, cfg_ready);
    end
    step();
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tests++;
      if (tick !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_tick cycle %0d tick %b busy %b exp 0 0", k, tick, busy);
      end
      step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      stop = (k == 3);
      tests++;
      if (tick !== (k == 3)) begin
        errors++;
        $display("FAIL reset_div cycle %0d tick %b exp %b", k, tick, (k == 3));
      end
      step();
    end
    stop = 1'b0;

    // Reset during HALT: no final tick afterwards.
    start = 1'b1;
    step();
    start = 1'b0; stop = 1'b1;
    step();
    stop = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tests++;
      if (tick !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_halt cycle %0d tick %b busy %b exp 0 0", k, tick, busy);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_cfg_load();
    test_stop_halt();
    test_start_stop_both();
    test_arbitration();
    test_req_zero();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
